// File: rtl/spike_rate_decoder_pkg.sv
// Shared types and defaults for the spike-rate decoder: FSM state encoding,
// default geometry and an index-width helper.
package spike_rate_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    localparam int DEF_N_OUT    = 4;
    localparam int DEF_T_WINDOW = 250;
    localparam int DEF_CNT_W    = 8;

    // Width needed to index 'value' items; never below 1 so single-line
    // configurations still get a legal vector.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/spike_rate_decoder_counter.sv
// Saturating per-line spike counter: clears on request, counts one per
// enabled cycle with inc high, and sticks at all-ones instead of wrapping.
module spike_counter
    import spike_rate_decoder_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (en && inc && (count_reg != CNT_MAX)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/spike_rate_decoder.sv
// Rate decoder: counts output-layer spikes over a fixed number of enabled
// cycles, then scans the counters one per cycle to find the most active line.
module spike_rate_decoder
    import spike_rate_decoder_pkg::*;
#(
    parameter int N_OUT    = DEF_N_OUT,
    parameter int T_WINDOW = DEF_T_WINDOW,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      start,
    input  logic [N_OUT-1:0]          spikes,
    output logic                      busy,
    output logic                      valid,
    input  logic                      ready,
    output logic [clog2(N_OUT)-1:0]   winner,
    output logic [CNT_W-1:0]          winner_cnt,
    output logic                      tie,
    output logic                      no_spike
);

    localparam int IDX_W = clog2(N_OUT);
    localparam int TMR_W = clog2(T_WINDOW + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(T_WINDOW - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_OUT - 1);

    state_t state_reg, state_next;

    logic [TMR_W-1:0]            timer_reg;
    logic [IDX_W-1:0]            idx_reg;
    logic [N_OUT-1:0][CNT_W-1:0] counts;
    logic                        clear_cnt;
    logic                        sample_en;
    logic                        window_done;
    logic                        resolve_done;

    logic [IDX_W-1:0]            winner_reg;
    logic [CNT_W-1:0]            winner_cnt_reg;
    logic                        tie_reg;
    logic                        no_spike_reg;

    logic [CNT_W-1:0]            cur_cnt;
    logic [IDX_W-1:0]            step_idx;
    logic [CNT_W-1:0]            step_cnt;
    logic                        step_tie;

    assign window_done  = (timer_reg == TMR_LAST);
    assign resolve_done = (idx_reg == IDX_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        clear_cnt  = 1'b0;
        sample_en  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    clear_cnt  = 1'b1;
                    state_next = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (en) begin
                    sample_en = 1'b1;
                    if (window_done) begin
                        state_next = ST_RESOLVE;
                    end
                end
            end
            ST_RESOLVE: begin
                if (resolve_done) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Timer counts enabled samples; the scan index is parked at 0 while counting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            timer_reg <= '0;
            idx_reg   <= '0;
        end else begin
            if (clear_cnt) begin
                timer_reg <= '0;
            end else if (sample_en) begin
                timer_reg <= timer_reg + 1'b1;
            end
            if (state_reg == ST_COUNT) begin
                idx_reg <= '0;
            end else if (state_reg == ST_RESOLVE) begin
                idx_reg <= idx_reg + 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_cnt
            spike_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .clear (clear_cnt),
                .en    (sample_en),
                .inc   (spikes[gi]),
                .count (counts[gi])
            );
        end
    endgenerate

    assign cur_cnt = counts[idx_reg];

    // One compare step: strictly greater takes over, equal keeps the lower index.
    always_comb begin
        step_idx = winner_reg;
        step_cnt = winner_cnt_reg;
        step_tie = tie_reg;
        if (idx_reg == '0) begin
            step_idx = '0;
            step_cnt = cur_cnt;
            step_tie = 1'b0;
        end else if (cur_cnt > winner_cnt_reg) begin
            step_idx = idx_reg;
            step_cnt = cur_cnt;
            step_tie = 1'b0;
        end else if (cur_cnt == winner_cnt_reg) begin
            step_tie = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            winner_reg     <= '0;
            winner_cnt_reg <= '0;
            tie_reg        <= 1'b0;
            no_spike_reg   <= 1'b0;
        end else if (state_reg == ST_RESOLVE) begin
            winner_reg     <= step_idx;
            winner_cnt_reg <= step_cnt;
            if (resolve_done) begin
                // A zero maximum means every line was silent; equal zeros are not a tie.
                tie_reg      <= step_tie && (step_cnt != '0);
                no_spike_reg <= (step_cnt == '0);
            end else begin
                tie_reg <= step_tie;
            end
        end
    end

    assign busy       = (state_reg == ST_COUNT) || (state_reg == ST_RESOLVE);
    assign valid      = (state_reg == ST_HOLD);
    assign winner     = winner_reg;
    assign winner_cnt = winner_cnt_reg;
    assign tie        = tie_reg;
    assign no_spike   = no_spike_reg;

endmodule
